// File: rtl/cs_acc_drain_if.sv
// Drain-side bundle of the carry-save accumulator column: snapshot request,
// carry-save buses in, and the valid/ready result stream out.
interface cs_acc_drain_if #(
    parameter int ACC_WIDTH = 32,
    parameter int ROWS      = 8,
    parameter int OUT_WIDTH = 16
);
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic                      drain_req;
    logic                      drain_ack;
    logic [ROWS*ACC_WIDTH-1:0] cs_sum_in;
    logic [ROWS*ACC_WIDTH-1:0] cs_carry_in;
    logic                      out_valid;
    logic                      out_ready;
    logic [OUT_WIDTH-1:0]      out_data;
    logic [ROW_W-1:0]          out_row;
    logic                      out_last;
    logic                      out_sat;
    logic                      busy;

    // master: the array/writeback side that requests drains and accepts beats
    modport master (
        output drain_req, cs_sum_in, cs_carry_in, out_ready,
        input  drain_ack, out_valid, out_data, out_row, out_last, out_sat, busy
    );

    modport slave (
        input  drain_req, cs_sum_in, cs_carry_in, out_ready,
        output drain_ack, out_valid, out_data, out_row, out_last, out_sat, busy
    );
endinterface

// File: rtl/cs_acc_drain.sv
// Snapshots ROWS carry-save accumulator pairs, resolves each with a CPA,
// rounds to OUT_WIDTH and streams one row per beat over valid/ready.
module cs_acc_drain #(
    parameter int ACC_WIDTH = 32,
    parameter int ROWS      = 8,
    parameter int OUT_WIDTH = 16,
    parameter int SAT_EN    = 1
) (
    input logic            clk,
    input logic            rst,
    cs_acc_drain_if.slave  bus
);
    localparam int PTR_W = $clog2(ROWS);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t               state, state_nxt;
    logic [ACC_WIDTH-1:0] snap_sum   [ROWS];
    logic [ACC_WIDTH-1:0] snap_carry [ROWS];
    logic [PTR_W-1:0]     ptr, ptr_nxt;
    logic [OUT_WIDTH-1:0] data_q, res_data;
    logic                 sat_q, res_sat;
    logic                 capture, advance, transfer, last;
    logic [ACC_WIDTH-1:0] src_sum, src_carry, full;

    assign last     = (ptr == PTR_W'(ROWS - 1));
    assign transfer = (state == STREAM) && bus.out_ready;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        advance   = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.drain_req) begin
                    capture   = 1'b1;
                    state_nxt = STREAM;
                end
            end
            STREAM: begin
                if (transfer) begin
                    if (!last)              advance   = 1'b1;
                    else if (bus.drain_req) capture   = 1'b1;
                    else                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Row 0 of a fresh snapshot is resolved straight from the input buses so
    // the first beat appears one cycle after the ack.
    always_comb begin
        ptr_nxt = ptr;
        if (capture)      ptr_nxt = '0;
        else if (advance) ptr_nxt = ptr + 1'b1;
    end

    assign src_sum   = capture ? bus.cs_sum_in[ACC_WIDTH-1:0]   : snap_sum[ptr_nxt];
    assign src_carry = capture ? bus.cs_carry_in[ACC_WIDTH-1:0] : snap_carry[ptr_nxt];
    assign full      = src_sum + src_carry;

    generate
        if (SAT_EN != 0 && OUT_WIDTH < ACC_WIDTH) begin : g_sat
            // In range only when every bit above the output sign bit matches it.
            always_comb begin
                res_data = full[OUT_WIDTH-1:0];
                res_sat  = 1'b0;
                if (full[ACC_WIDTH-1:OUT_WIDTH-1] !=
                    {(ACC_WIDTH-OUT_WIDTH+1){full[ACC_WIDTH-1]}}) begin
                    res_sat  = 1'b1;
                    res_data = full[ACC_WIDTH-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                                 : {1'b0, {(OUT_WIDTH-1){1'b1}}};
                end
            end
        end else begin : g_trunc
            assign res_data = full[OUT_WIDTH-1:0];
            assign res_sat  = 1'b0;
        end
    endgenerate

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            ptr    <= '0;
            data_q <= '0;
            sat_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (capture || advance) begin
                ptr    <= ptr_nxt;
                data_q <= res_data;
                sat_q  <= res_sat;
            end
        end
    end

    // NOTE: the snapshot array is reset too, so nothing stale survives a reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < ROWS; r++) begin
                snap_sum[r]   <= '0;
                snap_carry[r] <= '0;
            end
        end else if (capture) begin
            for (int r = 0; r < ROWS; r++) begin
                snap_sum[r]   <= bus.cs_sum_in[r*ACC_WIDTH +: ACC_WIDTH];
                snap_carry[r] <= bus.cs_carry_in[r*ACC_WIDTH +: ACC_WIDTH];
            end
        end
    end

    assign bus.drain_ack = capture;
    assign bus.out_valid = (state == STREAM);
    assign bus.busy      = (state == STREAM);
    assign bus.out_data  = data_q;
    assign bus.out_sat   = sat_q;
    assign bus.out_row   = ptr;
    assign bus.out_last  = (state == STREAM) && last;

endmodule

// File: doc/cs_acc_drain.md
Name: cs_acc_drain

Overview:
- Drain-side consumer of the carry-save accumulator column. Each MAC in the cube holds its accumulator as a redundant sum/carry pair.
- On a drain request, this block snapshots ROWS sum/carry pairs and resolves each with a carry-propagate adder.
- It rounds each result to OUT_WIDTH by saturation or truncation, then streams the results one row per beat over a valid/ready interface toward the writeback buffer.
- The snapshot frees the array to restart accumulation immediately.

Parameters:
- ACC_WIDTH, 32: width of each carry-save word (two's complement).
- ROWS, 8: number of accumulator rows captured per drain; must be ≥2.
- OUT_WIDTH, 16: width of each output result; must be ≤ ACC_WIDTH.
- SAT_EN, 1: 1 = saturate to signed OUT_WIDTH range; 0 = keep the low OUT_WIDTH bits.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- drain_req  in  1  request to capture the carry-save snapshot; level, sampled each cycle.
- drain_ack  out  1  combinational; high the cycle the snapshot is captured.
- cs_sum_in  in  ROWS*ACC_WIDTH  row r at bits [r*ACC_WIDTH +: ACC_WIDTH].
- cs_carry_in  in  ROWS*ACC_WIDTH  same packing as cs_sum_in.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accept.
- out_data  out  OUT_WIDTH  resolved and rounded result.
- out_row  out  clog2(ROWS)  row index of the current beat.
- out_last  out  1  high on the beat for row ROWS-1.
- out_sat  out  1  this beat was clipped (always 0 when SAT_EN=0).
- busy  out  1  snapshot held or streaming.

Behaviour:
- Reset (asynchronous, rst=1):
  - state=IDLE; out_valid, out_last, out_sat, busy = 0; out_row=0; out_data=0.
  - Snapshot registers cleared.
  - Reset mid-stream drops all pending beats; no partial completion.
- FSM states: IDLE, STREAM.
- IDLE:
  - drain_ack = drain_req.
  - On ack: capture both input buses into the snapshot, row pointer := 0, go to STREAM.
  - Next cycle: out_valid=1 with row 0 (one-cycle latency from ack to first beat).
- STREAM:
  - The output register holds row ptr. A beat is transferred when out_valid && out_ready.
  - While out_valid && !out_ready: out_data, out_row, out_last, out_sat hold stable.
  - On a transfer of a non-last row: ptr+1, next row presented the following cycle. No bubbles under continuous out_ready.
  - On a transfer of the last row with drain_req=0: go to IDLE; out_valid=0 and busy=0 next cycle.
  - On a transfer of the last row with drain_req=1: drain_ack=1 that cycle, new snapshot captured, remain in STREAM. Row 0 of the new snapshot is presented next cycle; out_valid never drops.
  - drain_req in STREAM at any other time: drain_ack=0; request ignored until eligible. The requester must hold drain_req.
- Resolution:
  - full = (sum + carry) mod 2^ACC_WIDTH, interpreted as signed.
  - SAT_EN=1: full > 2^(OUT_WIDTH-1)-1 → max, out_sat=1; full < -2^(OUT_WIDTH-1) → min, out_sat=1; otherwise full[OUT_WIDTH-1:0], out_sat=0.
  - SAT_EN=0: out_data = full[OUT_WIDTH-1:0], out_sat=0.
  - OUT_WIDTH == ACC_WIDTH: saturation never triggers.
- Output timing: the result for ptr is computed from the snapshot and registered into out_data at ptr update. The output is fully registered; no combinational path from out_ready to out_data.
- busy = (state==STREAM).
- out_row and out_last are derived from the registered ptr.

Test Plan:
- Single drain, ACC_WIDTH=32, OUT_WIDTH=16, SAT_EN=1, out_ready=1:
  - Stimulus: row r has sum=r*0x100, carry=r.
  - Required: 8 consecutive beats, data=r*257, out_row=0..7, out_last only on row 7, busy falls the cycle after the last beat.
- Saturation:
  - Positive: row 0 sum=0x00007000, carry=0x00002000 → out_data=0x7FFF, out_sat=1.
  - Negative: row 1 sum=0xFFFF0000, carry=0 → out_data=0x8000, out_sat=1.
  - Wrap: row 2 sum=0x80000000, carry=0x80000000 → out_data=0, out_sat=0.
- Backpressure:
  - Stimulus: out_ready=0 for 5 cycles on row 3.
  - Required: out_data and out_row stay at row 3 for all 5 cycles; no row skipped or duplicated after release.
- Back-to-back drains:
  - Stimulus: drain_req held high; inputs change immediately after the first ack.
  - Required: the second ack coincides with the row-7 handshake; row 0 of the second snapshot appears next cycle with out_valid continuous; first-stream data unaffected by the input change.
- Ignored request plus SAT_EN=0:
  - Stimulus: drain_req pulsed during row 2 of a stream.
  - Required: drain_ack=0 and the stream is unaffected.
  - With SAT_EN=0, sum=0x00012345, carry=0 → out_data=0x2345, out_sat=0.
- Reset mid-stream:
  - Stimulus: rst asserted asynchronously between edges during row 4.
  - Required: out_valid and busy drop immediately; after release, state is IDLE and the next drain starts at row 0.
